// File: rtl/rc4_encrypt.sv
// RC4 stream encryptor: runs KSA and PRGA against an external 256-byte S-RAM
// and XORs the keystream into a valid/ready plaintext stream.
module rc4_encrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  input  logic        pt_valid,
  input  logic [7:0]  pt_data,
  output logic        pt_ready,
  output logic        ct_valid,
  output logic [7:0]  ct_data,
  input  logic        ct_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [4:0] {
    IDLE, INIT,
    KSA_RD_I, KSA_WT_I, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J,
    PR_RD_I, PR_WT_I, PR_RD_J, PR_WT_J, PR_WR_I, PR_WR_J,
    PR_RD_F, PR_WT_F, PR_XOR, PR_OUT, DONE
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(MSG_LEN - 1);

  state_t      state;
  logic [7:0]  i, j, cnt, si, sj, f;
  logic [1:0]  k;
  logic [23:0] key;
  logic [7:0]  key_byte, ksa_j, prga_j;

  always_comb begin
    case (k)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  end

  // s_q holds s[i] in the WT_I states, so the new j is formed straight from it
  assign ksa_j  = j + s_q + key_byte;
  assign prga_j = j + s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= 8'd0;
      j         <= 8'd0;
      cnt       <= 8'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      f         <= 8'd0;
      k         <= 2'd0;
      key       <= 24'd0;
      s_address <= 8'd0;
      s_data    <= 8'd0;
      s_wren    <= 1'b0;
      pt_ready  <= 1'b0;
      ct_valid  <= 1'b0;
      ct_data   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= INIT;
            key       <= secret;
            i         <= 8'd0;
            j         <= 8'd0;
            k         <= 2'd0;
            cnt       <= 8'd0;
            s_address <= 8'd0;
            s_data    <= 8'd0;
            s_wren    <= 1'b1;
            busy      <= 1'b1;
          end
        end
        INIT: begin
          if (i == 8'd255) begin
            state     <= KSA_RD_I;
            i         <= 8'd0;
            j         <= 8'd0;
            s_wren    <= 1'b0;
            s_address <= 8'd0;
          end else begin
            i         <= i + 8'd1;
            s_address <= i + 8'd1;
            s_data    <= i + 8'd1;
          end
        end
        KSA_RD_I: state <= KSA_WT_I;
        KSA_WT_I: begin
          si        <= s_q;
          j         <= ksa_j;
          s_address <= ksa_j;
          state     <= KSA_RD_J;
        end
        KSA_RD_J: state <= KSA_WT_J;
        KSA_WT_J: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= KSA_WR_I;
        end
        KSA_WR_I: begin
          s_address <= j;
          s_data    <= si;
          state     <= KSA_WR_J;
        end
        KSA_WR_J: begin
          s_wren <= 1'b0;
          k      <= (k == 2'd2) ? 2'd0 : k + 2'd1;
          // PRGA starts from i=j=0; its first i increment is folded in here
          if (i == 8'd255) begin
            i         <= 8'd1;
            j         <= 8'd0;
            s_address <= 8'd1;
            state     <= PR_RD_I;
          end else begin
            i         <= i + 8'd1;
            s_address <= i + 8'd1;
            state     <= KSA_RD_I;
          end
        end
        PR_RD_I: state <= PR_WT_I;
        PR_WT_I: begin
          si        <= s_q;
          j         <= prga_j;
          s_address <= prga_j;
          state     <= PR_RD_J;
        end
        PR_RD_J: state <= PR_WT_J;
        PR_WT_J: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= PR_WR_I;
        end
        PR_WR_I: begin
          s_address <= j;
          s_data    <= si;
          state     <= PR_WR_J;
        end
        PR_WR_J: begin
          s_wren    <= 1'b0;
          s_address <= si + sj;
          state     <= PR_RD_F;
        end
        PR_RD_F: state <= PR_WT_F;
        PR_WT_F: begin
          f        <= s_q;
          pt_ready <= 1'b1;
          state    <= PR_XOR;
        end
        PR_XOR: begin
          if (pt_valid) begin
            ct_data  <= pt_data ^ f;
            ct_valid <= 1'b1;
            pt_ready <= 1'b0;
            state    <= PR_OUT;
          end
        end
        PR_OUT: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            cnt      <= cnt + 8'd1;
            if (cnt == LAST_BYTE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              i         <= i + 8'd1;
              s_address <= i + 8'd1;
              state     <= PR_RD_I;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
